// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - direct-mapped read-only instruction cache with 4-word burst refill
module icache_refill #(
  parameter int LINES       = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy,
  output logic [15:0] miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;
  localparam logic [3:0] FIRST_WORD = 4'(MEM_LATENCY);
  localparam logic [3:0] LAST_WORD  = 4'(MEM_LATENCY + 3);

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, RESP} state_t;

  state_t         state;
  logic [31:2]    addr_q;
  logic [LINES-1:0] valid;
  logic [TW-1:0]  tags [LINES];
  logic [31:0]    data [LINES*4];
  logic [3:0]     cyc;
  logic           flush_pend;

  logic [IW-1:0]  idx;
  logic [TW-1:0]  tag;
  logic [1:0]     off;
  logic [3:0]     fill_pos;
  logic           hit;
  logic           unused_addr_bits;

  assign idx      = addr_q[4+IW-1:4];
  assign tag      = addr_q[31:4+IW];
  assign off      = addr_q[3:2];
  assign fill_pos = cyc - FIRST_WORD;
  assign hit      = valid[idx] && (tags[idx] == tag);

  // The burst starts in the first REQ cycle that finds the memory idle.
  assign mem_enable      = (state == REQ) && !mem_busy;
  assign mem_rw          = 1'b0;
  assign mem_access_size = 2'b01;

  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      addr_q     <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      miss_count <= '0;
      cyc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      if (flush && (state != IDLE)) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (cpu_req) begin
            addr_q <= cpu_addr[31:2];
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_rdata <= data[{idx, off}];
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            mem_addr <= {addr_q[31:4], 4'b0000};
            state    <= REQ;
          end
        end
        REQ: begin
          if (!mem_busy) begin
            cyc   <= 4'd1;
            state <= FILL;
          end
        end
        FILL: begin
          // cyc counts cycles since the mem_enable cycle.
          if (cyc >= FIRST_WORD) data[{idx, fill_pos[1:0]}] <= mem_dout;
          if (cyc == LAST_WORD) begin
            valid[idx] <= 1'b1;
            tags[idx]  <= tag;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            state <= RESP;
          end
          cyc <= cyc + 4'd1;
        end
        RESP: begin
          cpu_rdata <= data[{idx, off}];
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - randomized self-checking bench for icache_refill
module tb_icache_refill;

  localparam int LINES = 16;
  localparam int ML    = 1;
  localparam int IW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_dout = '0;
  logic        mem_busy = 1'b0;
  logic [15:0] miss_count;

  int vectors = 0;
  int miscompares = 0;
  int en_count = 0;
  bit prev_en = 1'b0;

  bit          mv [LINES];
  logic [31:0] mt [LINES];
  int          mmiss;

  icache_refill #(.LINES(LINES), .MEM_LATENCY(ML)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_access_size(mem_access_size), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h8002000) return 32'((int'(a[3:2]) + 1) * 17);
    return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i;
    i = int'(a[4+IW-1:4]);
    return mv[i] && (mt[i] == (a >> (4 + IW)));
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int i;
    i = int'(a[4+IW-1:4]);
    mv[i] = 1'b1;
    mt[i] = a >> (4 + IW);
    if (mmiss < 65535) mmiss++;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endfunction

  // Memory side: one-cycle checks on every burst start, and the burst responder.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mem_enable) begin
        en_count++;
        vectors++;
        if (prev_en || mem_busy || mem_rw !== 1'b0 || mem_access_size !== 2'b01 || mem_addr[3:0] !== 4'h0) begin
          miscompares++;
          $display("FAIL mem_start: prev_en=%0b busy=%0b rw=%0b size=%b addr=%h required prev_en=0 busy=0 rw=0 size=01 aligned",
                   prev_en, mem_busy, mem_rw, mem_access_size, mem_addr);
        end
      end
      prev_en = mem_enable;
    end
  end

  initial begin
    logic [31:0] base;
    forever begin
      @(negedge clk);
      #1;
      if (mem_enable) begin
        base = mem_addr;
        repeat (ML) @(negedge clk);
        mem_dout = mem_word(base);
        for (int k = 1; k < 4; k++) begin
          @(negedge clk);
          mem_dout = mem_word(base + 32'(4 * k));
        end
        @(negedge clk);
        mem_dout = $urandom;
      end
    end
  end

  // mode 0: plain fetch, 1: flush pulse in the first fill cycle, 2: reset in the first fill cycle.
  task automatic do_fetch(input logic [31:0] a, input int mode, input int busy_end,
                          output int lat, output logic [31:0] data, output int en_cyc,
                          output logic [31:0] en_addr, output bit got);
    got = 1'b0; lat = -1; data = '0; en_cyc = -1; en_addr = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1;
        cpu_addr = a;
      end
      flush = (mode == 1 && en_cyc >= 0 && c == en_cyc + 1);
      mem_busy = (c < busy_end);
      if (mode == 2 && en_cyc >= 0 && c == en_cyc + 1) rst_n = 1'b0;
      if (mode == 2 && en_cyc >= 0 && c == en_cyc + 2) begin
        rst_n = 1'b1;
        cpu_req = 1'b0;
        #1;
        return;
      end
      #1;
      if (cpu_ready) begin
        got = 1'b1;
        lat = c;
        data = cpu_rdata;
        cpu_req = 1'b0;
        return;
      end
      if (mem_enable && en_cyc < 0) begin
        en_cyc = c;
        en_addr = mem_addr;
      end
    end
    cpu_req = 1'b0;
    flush = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({cpu_ready, cpu_rdata, mem_enable, mem_addr, miss_count, mem_rw, mem_access_size} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 16'h0, 1'b0, 2'b01}) begin
      miscompares++;
      $display("FAIL reset_state: ready=%0b rdata=%h en=%0b addr=%h misses=%0d rw=%0b size=%b required all zero, size=01",
               cpu_ready, cpu_rdata, mem_enable, mem_addr, miss_count, mem_rw, mem_access_size);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    mmiss = 0;
  endtask

  task automatic test_cold_miss();
    int lat, ec, e0; logic [31:0] d, ea; bit got;
    e0 = en_count;
    do_fetch(32'h8002_0008, 0, 0, lat, d, ec, ea, got);
    model_fill(32'h8002_0008);
    vectors++;
    if (!got || d !== 32'h33) begin miscompares++; $display("FAIL cold_data: got=%0b rdata=%h required 00000033", got, d); end
    vectors++;
    if (en_count - e0 != 1 || ea !== 32'h8002_0000 || ec != 2) begin
      miscompares++;
      $display("FAIL cold_burst: pulses=%0d addr=%h cycle=%0d required 1 80020000 2", en_count - e0, ea, ec);
    end
    vectors++;
    if (miss_count !== 16'd1) begin miscompares++; $display("FAIL cold_count: %0d required 1", miss_count); end
  endtask

  task automatic test_hit();
    int lat, ec, e0; logic [31:0] d, ea; bit got;
    e0 = en_count;
    do_fetch(32'h8002_000C, 0, 0, lat, d, ec, ea, got);
    vectors++;
    if (!got || lat != 2 || d !== 32'h44) begin
      miscompares++;
      $display("FAIL hit: got=%0b latency=%0d rdata=%h required 1 2 00000044", got, lat, d);
    end
    vectors++;
    if (en_count != e0 || miss_count !== 16'd1) begin
      miscompares++;
      $display("FAIL hit_quiet: pulses=%0d misses=%0d required 0 1", en_count - e0, miss_count);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    int lat, ec, e0; logic [31:0] d, ea; bit got;
    seq[0] = 32'h8002_0000; seq[1] = 32'h8002_0100; seq[2] = 32'h8002_0000;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_flush(); mmiss = 0;
    for (int i = 0; i < 3; i++) begin
      e0 = en_count;
      do_fetch(seq[i], 0, 0, lat, d, ec, ea, got);
      model_fill(seq[i]);
      vectors++;
      if (!got || d !== mem_word(seq[i]) || en_count - e0 != 1 || ea !== {seq[i][31:4], 4'h0}) begin
        miscompares++;
        $display("FAIL conflict[%0d]: got=%0b rdata=%h pulses=%0d addr=%h required rdata=%h pulses=1",
                 i, got, d, en_count - e0, ea, mem_word(seq[i]));
      end
    end
    vectors++;
    if (miss_count !== 16'd3) begin miscompares++; $display("FAIL conflict_count: %0d required 3", miss_count); end
  endtask

  task automatic test_busy();
    int lat, ec; logic [31:0] d, ea; bit got;
    do_fetch(32'h0000_4564, 0, 7, lat, d, ec, ea, got);
    model_fill(32'h0000_4564);
    vectors++;
    if (!got || ec != 7 || d !== mem_word(32'h0000_4564)) begin
      miscompares++;
      $display("FAIL busy_stall: got=%0b enable_cycle=%0d rdata=%h required 1 7 %h", got, ec, d, mem_word(32'h0000_4564));
    end
  endtask

  task automatic test_flush_mid_fill();
    int lat, ec, e0; logic [31:0] d, ea; bit got;
    logic [31:0] a;
    a = 32'h1234_5678;
    do_fetch(a, 1, 0, lat, d, ec, ea, got);
    model_fill(a);
    model_flush();
    vectors++;
    if (!got || d !== mem_word({a[31:2], 2'b00})) begin
      miscompares++;
      $display("FAIL flush_fill_answer: got=%0b rdata=%h required %h", got, d, mem_word({a[31:2], 2'b00}));
    end
    e0 = en_count;
    do_fetch(a, 0, 0, lat, d, ec, ea, got);
    model_fill(a);
    vectors++;
    if (!got || en_count - e0 != 1 || d !== mem_word({a[31:2], 2'b00}) || miss_count !== 16'(mmiss)) begin
      miscompares++;
      $display("FAIL flush_refetch: got=%0b pulses=%0d rdata=%h misses=%0d required 1 1 %h %0d",
               got, en_count - e0, d, miss_count, mem_word({a[31:2], 2'b00}), mmiss);
    end
  endtask

  task automatic test_reset_mid_fill();
    int lat, ec, e0; logic [31:0] d, ea; bit got;
    logic [31:0] a;
    a = 32'h0BAD_F00C;
    do_fetch(a, 2, 0, lat, d, ec, ea, got);
    model_flush(); mmiss = 0;
    vectors++;
    if (got || {cpu_ready, cpu_rdata, mem_enable, mem_addr, miss_count} !== {1'b0, 32'h0, 1'b0, 32'h0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_fill_state: got=%0b ready=%0b rdata=%h en=%0b addr=%h misses=%0d required all zero",
               got, cpu_ready, cpu_rdata, mem_enable, mem_addr, miss_count);
    end
    repeat (4) @(negedge clk);
    e0 = en_count;
    do_fetch(a, 0, 0, lat, d, ec, ea, got);
    model_fill(a);
    vectors++;
    if (!got || en_count - e0 != 1 || d !== mem_word(a) || miss_count !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_refetch: got=%0b pulses=%0d rdata=%h misses=%0d required 1 1 %h 1",
               got, en_count - e0, d, miss_count, mem_word(a));
    end
  endtask

  task automatic test_back_to_back();
    int lat, ec, e0; logic [31:0] d, ea, base, cur; bit got;
    base = 32'h0077_0040;
    do_fetch(base, 0, 0, lat, d, ec, ea, got);
    model_fill(base);
    e0 = en_count;
    cur = base;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = cur;
    for (int i = 0; i < 8; i++) begin
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        #1;
        if (cpu_ready) begin lat = c; break; end
      end
      vectors++;
      if (lat != 2 || cpu_rdata !== mem_word(cur)) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: latency=%0d rdata=%h required 2 %h", i, lat, cpu_rdata, mem_word(cur));
      end
      cur = base + 32'(4 * ((i + 1) % 4));
      if (i < 7) cpu_addr = cur;
      else cpu_req = 1'b0;
    end
    vectors++;
    if (en_count != e0) begin miscompares++; $display("FAIL back_to_back_quiet: pulses=%0d required 0", en_count - e0); end
  endtask

  task automatic test_random();
    int lat, ec, e0, be; logic [31:0] d, ea, a; bit got, h;
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(1, 3)) << 24) | (32'($urandom_range(0, LINES - 1)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        model_flush();
      end
      be = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 0;
      h = model_hit(a);
      e0 = en_count;
      do_fetch(a, 0, be, lat, d, ec, ea, got);
      if (!h) model_fill(a);
      vectors++;
      if (!got || d !== mem_word({a[31:2], 2'b00}) || en_count - e0 != (h ? 0 : 1) ||
          (h && lat != 2) || miss_count !== 16'(mmiss)) begin
        miscompares++;
        $display("FAIL random[%0d] addr=%h: got=%0b rdata=%h pulses=%0d latency=%0d misses=%0d required rdata=%h pulses=%0d hit=%0b misses=%0d",
                 n, a, got, d, en_count - e0, lat, miss_count, mem_word({a[31:2], 2'b00}), h ? 0 : 1, h, mmiss);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_busy();
    test_flush_mid_fill();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    repeat (6) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the burst-capable main memory block.
- Serves fetch hits from local storage with one-cycle latency.
- On a miss, issues one 4-word burst read to memory, fills the line, then answers the fetch.
- Memory-side port names and encodings match the memory block: access_size 2'b01 = 4-word burst, rw 0 = read.

Parameters:
- LINES, 16: number of cache lines; power of two, at least 2; index width IW = log2(LINES).
- MEM_LATENCY, 1: cycles from the mem_enable cycle to the first valid burst word on mem_dout; range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- cpu_req  input  1  fetch request; CPU holds it and cpu_addr stable until cpu_ready.
- cpu_addr  input  32  fetch byte address; bits [1:0] ignored.
- cpu_rdata  output  32  fetched instruction word; valid when cpu_ready=1.
- cpu_ready  output  1  one-cycle pulse completing the current request.
- flush  input  1  invalidate all lines.
- mem_addr  output  32  burst start address, line aligned (bits [3:0]=0).
- mem_enable  output  1  one-cycle burst start pulse.
- mem_rw  output  1  constant 0 (read only).
- mem_access_size  output  2  constant 2'b01 (4-word burst).
- mem_dout  input  32  burst data from memory, one word per cycle.
- mem_busy  input  1  memory busy; a burst must not start while it is high.
- miss_count  output  16  number of completed refills; saturates at 16'hFFFF.

Behaviour:
- Address split: offset = addr[3:2]; index = addr[4+IW-1:4]; tag = addr[31:4+IW].
- Storage per line: valid bit, tag, 4 data words.
- Reset (rst_n=0 at a clock edge):
  - All valid bits cleared; state goes to IDLE.
  - cpu_ready=0, cpu_rdata=0, mem_enable=0, mem_addr=0, miss_count=0.
  - Applies in any state, including mid-burst. Remaining burst words are ignored.
- FSM states: IDLE, LOOKUP, REQ, FILL, RESP.
- IDLE:
  - If a flush is pending or flush=1, clear all valid bits this cycle and stay in IDLE; flush takes priority over cpu_req.
  - Otherwise, if cpu_req=1, register the address and go to LOOKUP.
- LOOKUP:
  - Hit (valid and tag match): drive cpu_rdata with the word at the offset, pulse cpu_ready, go to IDLE.
  - Hit latency: request sampled at edge t, cpu_ready high in the cycle after edge t+1.
  - Miss: go to REQ.
- REQ:
  - Wait while mem_busy=1.
  - When mem_busy=0: drive mem_addr = {addr[31:4], 4'b0}, pulse mem_enable for exactly one cycle, reset the word counter, go to FILL.
- FILL:
  - Word k (k = 0..3) is captured from mem_dout on the edge ending the cycle that is MEM_LATENCY+k cycles after the mem_enable cycle.
  - Words are written in order: addresses line+0, +4, +8, +12.
  - After word 3: set the tag and valid bit, increment miss_count (saturating), go to RESP.
- RESP: drive cpu_rdata with the requested word from the filled line, pulse cpu_ready, go to IDLE.
- Back-to-back requests: cpu_req sampled in the IDLE cycle directly after cpu_ready is a new request; the best sustained hit rate is one word per 2 cycles.
- flush outside IDLE: latched into a pending flag; the refill in progress completes and is answered, then all lines are invalidated on return to IDLE.
- cpu_req low in LOOKUP, REQ, FILL or RESP: protocol violation, behaviour undefined. The bench does not generate it.
- Tag compare uses the registered address only.
- mem_enable is never high in two consecutive cycles.
- mem_rw and mem_access_size are constant.

Test Plan:
- Cold miss: after reset, fetch 0x8002_0008 with memory words 0x11,0x22,0x33,0x44 at 0x8002_0000..0C -> exactly one mem_enable pulse with mem_addr=0x8002_0000; cpu_rdata=0x33; miss_count=1.
- Hit: then fetch 0x8002_000C -> cpu_ready exactly 2 cycles after the request cycle, cpu_rdata=0x44, no mem_enable, miss_count stays 1.
- Conflict: fetch 0x8002_0000, then 0x8002_0100 (same index with LINES=16), then 0x8002_0000 -> three refills, miss_count=3, correct data each time.
- Busy stall: mem_busy held high for 5 cycles at the miss -> mem_enable asserted only in the first cycle with mem_busy=0; data correct.
- Flush mid-fill: flush pulsed during FILL -> current fetch answered correctly; the same address fetched again misses; miss_count increments.
- Reset mid-fill: rst_n low for one cycle during FILL -> outputs return to reset values; the next fetch of that line misses and refills correctly.
